shift_sequencer: RTL and testbench

//  Multi-cycle shift unit that sits in front of the shifter datapath. It takes a shift request
//  (operand, amount, mode), applies a one-bit shift per clock, and returns the result.
//  It uses a valid/ready handshake on both the request side and the result side.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 22 ++
 rtl/shift_sequencer.sv | 91 +++++++++
 tb/tb_shift_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer: shift modes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SRL  = 2'b00,
        SHIFT_SLL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_RSVD = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift of a data word according to the shift mode; reserved mode yields zero.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  shift_mode_e        mode,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q
);

    always_comb begin
        q = '0;
        case (mode)
            SHIFT_SRL: q = {1'b0, d[WIDTH-1:1]};
            SHIFT_SLL: q = {d[WIDTH-2:0], 1'b0};
            SHIFT_SRA: q = {d[WIDTH-1], d[WIDTH-1:1]};
            default:   q = '0;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts a request, shifts one bit per clock, presents the result
// with a valid/ready handshake. Kill flushes any in-flight work.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_mode,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_kill,
    output logic               o_valid,
    input  logic               i_res_ready,
    output logic [WIDTH-1:0]   o_result
);

    seq_state_e         state;
    shift_mode_e        mode_q;
    logic [SHAMT_W-1:0] count;
    logic [WIDTH-1:0]   data;

    shift_mode_e        step_mode;
    logic [WIDTH-1:0]   step_in;
    logic [WIDTH-1:0]   step_out;
    shift_mode_e        req_mode;

    assign req_mode = shift_mode_e'(i_mode);

    // The first shift is applied at accept, so an N-bit shift finishes N edges later.
    assign step_mode = (state == ST_IDLE) ? req_mode  : mode_q;
    assign step_in   = (state == ST_IDLE) ? i_operand : data;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode (step_mode),
        .d    (step_in),
        .q    (step_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            mode_q <= SHIFT_SRL;
            count  <= '0;
            data   <= '0;
        end else if (i_kill) begin
            state  <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        mode_q <= req_mode;
                        if (req_mode == SHIFT_RSVD) begin
                            data  <= '0;
                            count <= '0;
                            state <= ST_DONE;
                        end else if (i_shamt == '0) begin
                            data  <= i_operand;
                            count <= '0;
                            state <= ST_DONE;
                        end else begin
                            data  <= step_out;
                            count <= i_shamt - SHAMT_W'(1);
                            state <= (i_shamt == SHAMT_W'(1)) ? ST_DONE : ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data  <= step_out;
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_res_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready  = (state == ST_IDLE) && !i_reset;
    assign o_valid  = (state == ST_DONE);
    assign o_result = data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed corner cases plus randomized regression
// against a plain-arithmetic shift model.
module tb_shift_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_mode = 2'b00;
    logic [4:0]  i_shamt = '0;
    logic [31:0] i_operand = '0;
    logic        i_kill = 1'b0;
    logic        o_valid;
    logic        i_res_ready = 1'b1;
    logic [31:0] o_result;

    shift_sequencer #(.WIDTH(32)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_mode      (i_mode),
        .i_shamt     (i_shamt),
        .i_operand   (i_operand),
        .i_kill      (i_kill),
        .o_valid     (o_valid),
        .i_res_ready (i_res_ready),
        .o_result    (o_result)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] held = '0;
    int          rr_mode = 0;   // 0: always ready, 1: random, 2: manual
    logic        kill_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] m, input int sh,
                                              input logic [31:0] op);
        case (m)
            2'b00:   return op >> sh;
            2'b01:   return op << sh;
            2'b10:   return 32'($signed(op) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: samples on the falling edge, predicts accepts for the coming rising edge.
    always @(negedge i_clk) begin
        cyc++;
        if (o_valid) begin
            if (!prev_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=%h expected=none", o_result);
                end else begin
                    mon_e = q.pop_front();
                    chk("result", o_result, mon_e.res);
                    chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    held = o_result;
                end
            end else begin
                chk("hold_result", o_result, held);
            end
        end
        if (i_reset || i_kill) begin
            q.delete();
        end else if (i_valid && o_ready) begin
            mon_e.res = ref_shift(i_mode, int'(i_shamt), i_operand);
            mon_e.lat = (i_mode == 2'b11 || i_shamt == 0) ? 1 : int'(i_shamt);
            mon_e.acc = cyc;
            q.push_back(mon_e);
        end
        prev_valid = o_valid && !i_res_ready && !i_kill && !i_reset;
    end

    always @(posedge i_clk) begin
        #1;
        if (rr_mode == 0) i_res_ready = 1'b1;
        else if (rr_mode == 1) i_res_ready = 1'($urandom_range(0, 1));
        if (kill_en) i_kill = ($urandom_range(0, 39) == 0);
    end

    task automatic send(input logic [1:0] m, input int sh, input logic [31:0] op);
        int n;
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_mode = m; i_shamt = 5'(sh); i_operand = op;
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 300) chk("send_timeout", 32'(n), 32'(0));
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_mode = 2'($urandom); i_shamt = 5'($urandom); i_operand = $urandom;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_valid && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) chk(name, 32'(n), 32'(0));
    endtask

    task automatic send_chk(input string name, input logic [1:0] m, input int sh,
                            input logic [31:0] op, input logic [31:0] exp);
        send(m, sh, op);
        wait_valid({name, "_timeout"});
        chk(name, o_result, exp);
    endtask

    initial begin
        int seen;
        int n;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready",  {31'b0, o_ready}, 32'd0);
        chk("rst_valid",  {31'b0, o_valid}, 32'd0);
        chk("rst_result", o_result, 32'h0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("post_rst_ready", {31'b0, o_ready}, 32'd1);

        send_chk("srl4",     2'b00, 4,  32'h8000_0000, 32'h0800_0000);
        send_chk("sra4_neg", 2'b10, 4,  32'h8000_0000, 32'hF800_0000);
        send_chk("sra4_pos", 2'b10, 4,  32'h7000_0000, 32'h0700_0000);
        send_chk("sll31",    2'b01, 31, 32'h0000_0001, 32'h8000_0000);
        send_chk("sll1",     2'b01, 1,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        send_chk("srl0",     2'b00, 0,  32'h1234_5678, 32'h1234_5678);
        send_chk("sll0",     2'b01, 0,  32'h1234_5678, 32'h1234_5678);
        send_chk("sra0",     2'b10, 0,  32'h1234_5678, 32'h1234_5678);
        send_chk("rsvd7",    2'b11, 7,  32'hDEAD_BEEF, 32'h0);

        // Backpressure: result held, no new accept while stalled.
        rr_mode = 2;
        @(posedge i_clk); #1;
        i_res_ready = 1'b0;
        send(2'b00, 4, 32'h8000_0000);
        wait_valid("bp_timeout");
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_mode = 2'b01; i_shamt = 5'd3; i_operand = 32'h5555_5555;
        repeat (10) begin
            @(negedge i_clk);
            chk("bp_valid",  {31'b0, o_valid}, 32'd1);
            chk("bp_result", o_result, 32'h0800_0000);
            chk("bp_ready",  {31'b0, o_ready}, 32'd0);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_res_ready = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("release_valid", {31'b0, o_valid}, 32'd0);
        chk("release_ready", {31'b0, o_ready}, 32'd1);
        rr_mode = 0;

        // Kill together with valid in IDLE: no accept.
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_mode = 2'b00; i_shamt = 5'd0; i_operand = 32'hCAFE_F00D; i_kill = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_kill = 1'b0;
        @(negedge i_clk);
        chk("kill_idle_valid", {31'b0, o_valid}, 32'd0);
        chk("kill_idle_ready", {31'b0, o_ready}, 32'd1);

        // Kill mid-shift with two shifts remaining.
        send(2'b00, 8, 32'hFF00_FF00);
        repeat (5) @(posedge i_clk);
        #1 i_kill = 1'b1;
        @(posedge i_clk); #1;
        i_kill = 1'b0;
        @(negedge i_clk);
        chk("kill_shift_ready", {31'b0, o_ready}, 32'd1);
        seen = 0;
        repeat (12) begin
            if (o_valid) seen = 1;
            @(negedge i_clk);
        end
        chk("kill_shift_no_valid", 32'(seen), 32'd0);

        // Kill and consume together in DONE: result dropped.
        rr_mode = 2;
        @(posedge i_clk); #1;
        i_res_ready = 1'b0;
        send(2'b00, 2, 32'h0000_00F0);
        wait_valid("kill_done_timeout");
        @(posedge i_clk); #1;
        i_kill = 1'b1; i_res_ready = 1'b1;
        @(posedge i_clk); #1;
        i_kill = 1'b0;
        @(negedge i_clk);
        chk("kill_done_valid", {31'b0, o_valid}, 32'd0);
        chk("kill_done_ready", {31'b0, o_ready}, 32'd1);
        rr_mode = 0;

        // Reset in the middle of a shift.
        send(2'b01, 10, 32'h0F0F_0F0F);
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(negedge i_clk);
        chk("midrst_ready",  {31'b0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("midrst_valid",  {31'b0, o_valid}, 32'd0);
        chk("midrst_result", o_result, 32'h0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("midrst_release_ready", {31'b0, o_ready}, 32'd1);

        // Randomized regression with backpressure and occasional flushes.
        rr_mode = 1;
        kill_en = 1'b1;
        for (int i = 0; i < 150; i++)
            send(2'($urandom), int'($urandom_range(0, 31)), $urandom);
        kill_en = 1'b0;
        rr_mode = 0;
        @(posedge i_clk); #1;
        i_kill = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge i_clk);
            n++;
        end
        @(negedge i_clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
